dac_excitation_sequencer: RTL and testbench

//  Sequences dac_controller to generate the EIT sinusoidal excitation current.
//  It steps an internal 64-entry signed sine ROM at a programmed sample rate and

---
 rtl/dac_excitation_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_dac_excitation_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_excitation_sequencer.sv
// -----------------------------------------------------------------------------
// dac_excitation_sequencer
//
// Drives dac_controller to produce the EIT sinusoidal excitation current.
// An internal 64-entry signed sine table is stepped at a programmable sample
// rate. Each sample is attenuated by an arithmetic right shift and converted
// to an offset-binary DAC code. Every code is sent with a start_dac/dac_done
// handshake. A burst runs a set number of sine periods, or runs until abort.
// It then ends with one "park" write of midscale, so the electrode current
// returns to zero.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   start         1-cycle pulse, begins a burst (ignored while busy)
//   abort         1-cycle pulse, ends a burst early (ignored when idle)
//   sample_div    clocks per sample, latched at start, values below 2 act as 2
//   num_cycles    sine periods per burst, latched at start, 0 = until abort
//   amp_shift     attenuation shift, latched at start
//   start_dac     1-cycle transfer request to dac_controller
//   dac_val       code to the DAC, held from start_dac until dac_done
//   dac_done      1-cycle transfer completion from dac_controller
//   busy          high while a burst (including its park write) is active
//   burst_done    1-cycle pulse once the park write has completed
//   overrun       sticky flag, a sample tick was lost; cleared on next start
//   sample_idx    table index of the last issued sample
//   cycle_cnt     sine periods completed in the current burst
// -----------------------------------------------------------------------------
module dac_excitation_sequencer #(
    parameter int DATA_W = 16,
    parameter int LUT_AW = 6,
    parameter int DIV_W  = 16,
    parameter int CYC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DIV_W-1:0]  sample_div,
    input  logic [CYC_W-1:0]  num_cycles,
    input  logic [3:0]        amp_shift,
    output logic              start_dac,
    output logic [DATA_W-1:0] dac_val,
    input  logic              dac_done,
    output logic              busy,
    output logic              burst_done,
    output logic              overrun,
    output logic [LUT_AW-1:0] sample_idx,
    output logic [CYC_W-1:0]  cycle_cnt
);

    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DIV_W-1:0]  MIN_DIV  = DIV_W'(2);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        WAIT_TICK,
        PARK,
        PARK_WAIT
    } state_t;

    // First quadrant of the sine, round(32767 * sin(k * pi / 32)), k = 0..16.
    // The other three quadrants are made by mirroring and negation.
    function automatic logic [14:0] quarter_mag(input logic [4:0] k);
        logic [14:0] m;
        case (k)
            5'd0:    m = 15'd0;
            5'd1:    m = 15'd3212;
            5'd2:    m = 15'd6393;
            5'd3:    m = 15'd9512;
            5'd4:    m = 15'd12539;
            5'd5:    m = 15'd15446;
            5'd6:    m = 15'd18204;
            5'd7:    m = 15'd20787;
            5'd8:    m = 15'd23170;
            5'd9:    m = 15'd25329;
            5'd10:   m = 15'd27245;
            5'd11:   m = 15'd28898;
            5'd12:   m = 15'd30273;
            5'd13:   m = 15'd31356;
            5'd14:   m = 15'd32137;
            5'd15:   m = 15'd32609;
            default: m = 15'd32767;
        endcase
        return m;
    endfunction

    // Index bit 4 mirrors inside the half period (the 16 - pos reflection).
    // Index bit 5 selects the negative half.
    function automatic logic signed [15:0] sine_lut(input logic [5:0] i);
        logic [4:0]  k;
        logic [14:0] m;
        k = i[4] ? (5'd16 - {1'b0, i[3:0]}) : {1'b0, i[3:0]};
        m = quarter_mag(k);
        return i[5] ? -$signed({1'b0, m}) : $signed({1'b0, m});
    endfunction

    // The shift result is held in a signed variable before the offset is
    // added. Mixing it with the unsigned constant in one expression would
    // turn the arithmetic shift into a logical shift.
    function automatic logic [15:0] dac_code(input logic [5:0] i, input logic [3:0] sh);
        logic signed [15:0] scaled;
        scaled = sine_lut(i) >>> sh;
        return 16'h8000 + scaled;
    endfunction

    state_t              state, state_n;
    logic [LUT_AW-1:0]   idx, idx_n;
    logic [LUT_AW-1:0]   sample_idx_n;
    logic [CYC_W-1:0]    cycle_cnt_n, cnt_after;
    logic                overrun_n;
    logic [DIV_W-1:0]    timer, timer_n;
    logic                tick_pending, tick_pending_n;
    logic                abort_lat, abort_lat_n;
    logic [DIV_W-1:0]    div_lat, div_n;
    logic [CYC_W-1:0]    ncyc_lat, ncyc_n;
    logic [3:0]          shift_lat, shift_n;
    logic [DATA_W-1:0]   dac_val_n;
    logic                burst_done_n;
    logic                timer_run, tick, wrap, stop_req;

    // State register and all datapath registers. Reset returns the DAC code
    // to midscale immediately, because dac_controller shares this reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            sample_idx   <= '0;
            cycle_cnt    <= '0;
            overrun      <= 1'b0;
            timer        <= '0;
            tick_pending <= 1'b0;
            abort_lat    <= 1'b0;
            div_lat      <= MIN_DIV;
            ncyc_lat     <= '0;
            shift_lat    <= '0;
            dac_val      <= MIDSCALE;
            burst_done   <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            sample_idx   <= sample_idx_n;
            cycle_cnt    <= cycle_cnt_n;
            overrun      <= overrun_n;
            timer        <= timer_n;
            tick_pending <= tick_pending_n;
            abort_lat    <= abort_lat_n;
            div_lat      <= div_n;
            ncyc_lat     <= ncyc_n;
            shift_lat    <= shift_n;
            dac_val      <= dac_val_n;
            burst_done   <= burst_done_n;
        end
    end

    // The sample timer runs only while samples are being produced. It does
    // not run in idle or during the park write. A tick that arrives while the
    // FSM is not waiting for one is queued once. A second queued tick is
    // dropped and flagged, so the table index never skips a sample.
    always_comb begin
        timer_run = (state == ISSUE) || (state == WAIT_DONE) || (state == WAIT_TICK);
        tick      = timer_run && (timer == (div_lat - 1'b1));
        wrap      = (idx == {LUT_AW{1'b1}});
        cnt_after = cycle_cnt + {{(CYC_W-1){1'b0}}, wrap};
        stop_req  = abort_lat || abort;
    end

    // Next-state and output decode. The code for the next sample is loaded
    // into dac_val as ISSUE is entered, so it is valid together with start_dac.
    always_comb begin
        state_n        = state;
        idx_n          = idx;
        sample_idx_n   = sample_idx;
        cycle_cnt_n    = cycle_cnt;
        overrun_n      = overrun;
        timer_n        = timer;
        tick_pending_n = tick_pending;
        abort_lat_n    = abort_lat;
        div_n          = div_lat;
        ncyc_n         = ncyc_lat;
        shift_n        = shift_lat;
        dac_val_n      = dac_val;
        burst_done_n   = 1'b0;
        start_dac      = 1'b0;

        if (timer_run) begin
            timer_n = tick ? '0 : timer + 1'b1;
        end

        if (tick && (state != WAIT_TICK)) begin
            if (tick_pending) begin
                overrun_n = 1'b1;
            end else begin
                tick_pending_n = 1'b1;
            end
        end

        if (abort && (state != IDLE)) begin
            abort_lat_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    div_n          = (sample_div < MIN_DIV) ? MIN_DIV : sample_div;
                    ncyc_n         = num_cycles;
                    shift_n        = amp_shift;
                    idx_n          = '0;
                    sample_idx_n   = '0;
                    cycle_cnt_n    = '0;
                    overrun_n      = 1'b0;
                    timer_n        = '0;
                    tick_pending_n = 1'b0;
                    abort_lat_n    = 1'b0;
                    dac_val_n      = DATA_W'(dac_code(6'd0, amp_shift));
                    state_n        = ISSUE;
                end
            end
            ISSUE: begin
                start_dac = 1'b1;
                state_n   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (dac_done) begin
                    cycle_cnt_n = cnt_after;
                    if (((ncyc_lat != '0) && (cnt_after == ncyc_lat)) || stop_req) begin
                        dac_val_n = MIDSCALE;
                        state_n   = PARK;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = WAIT_TICK;
                    end
                end
            end
            WAIT_TICK: begin
                // No transfer is in flight here, so a pending abort can park
                // right away instead of issuing one more sample.
                if (stop_req) begin
                    dac_val_n = MIDSCALE;
                    state_n   = PARK;
                end else if (tick_pending || tick) begin
                    // A queued tick is used first. A tick arriving in the same
                    // cycle takes its place in the queue.
                    tick_pending_n = tick_pending && tick;
                    sample_idx_n   = idx;
                    dac_val_n      = DATA_W'(dac_code(idx, shift_lat));
                    state_n        = ISSUE;
                end
            end
            PARK: begin
                start_dac = 1'b1;
                state_n   = PARK_WAIT;
            end
            PARK_WAIT: begin
                if (dac_done) begin
                    burst_done_n = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // burst_done is registered, so busy falls in the same cycle it pulses.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dac_excitation_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dac_excitation_sequencer
//
// Directed bench for dac_excitation_sequencer. A behavioural dac_controller
// model answers every start_dac with a dac_done a programmable number of
// clocks later. It also logs each issued code and the cycle it was issued in.
// Each scenario task drives its own stimulus and checks hand-computed values.
// -----------------------------------------------------------------------------
module tb_dac_excitation_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] sample_div;
    logic [7:0]  num_cycles;
    logic [3:0]  amp_shift;
    logic        start_dac;
    logic [15:0] dac_val;
    logic        dac_done;
    logic        busy;
    logic        burst_done;
    logic        overrun;
    logic [5:0]  sample_idx;
    logic [7:0]  cycle_cnt;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          dac_lat = 3;
    int          dac_cnt = 0;
    int          pulse_cnt = 0;
    int          done_cnt = 0;
    int          unstable = 0;
    logic        holding = 1'b0;
    logic [15:0] held_val = 16'h0;
    logic        inject_done = 1'b0;
    logic [15:0] codes[$];
    int          times[$];

    dac_excitation_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .sample_div (sample_div),
        .num_cycles (num_cycles),
        .amp_shift  (amp_shift),
        .start_dac  (start_dac),
        .dac_val    (dac_val),
        .dac_done   (dac_done),
        .busy       (busy),
        .burst_done (burst_done),
        .overrun    (overrun),
        .sample_idx (sample_idx),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // dac_controller model, evaluated on the falling edge. A request seen in
    // cycle t completes with dac_done high during cycle t + dac_lat. The model
    // also records every request and notes whether dac_val moved mid-transfer.
    always @(negedge clk) begin
        if (rst) begin
            dac_cnt  = 0;
            dac_done = 1'b0;
            holding  = 1'b0;
        end else begin
            if (holding && (dac_val !== held_val)) unstable++;
            dac_done = inject_done;
            if (dac_cnt > 0) begin
                dac_cnt--;
                if (dac_cnt == 0) begin
                    dac_done = 1'b1;
                    holding  = 1'b0;
                end
            end
            if (start_dac) begin
                dac_cnt  = dac_lat;
                holding  = 1'b1;
                held_val = dac_val;
                codes.push_back(dac_val);
                times.push_back(cyc);
                pulse_cnt++;
            end
            if (burst_done) done_cnt++;
        end
    end

    task automatic clear_logs();
        codes.delete();
        times.delete();
        pulse_cnt = 0;
        done_cnt  = 0;
        unstable  = 0;
    endtask

    task automatic launch(input logic [15:0] div, input logic [7:0] ncyc, input logic [3:0] sh);
        @(negedge clk);
        clear_logs();
        sample_div = div;
        num_cycles = ncyc;
        amp_shift  = sh;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_burst(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Values during and right after reset.
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        sample_div = 16'd8;
        num_cycles = 8'd1;
        amp_shift = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (start_dac !== 1'b0) begin errors++; $display("[TB] FAIL reset_start_dac: got %b expected 0", start_dac); end
        checks++; if (dac_val !== 16'h8000) begin errors++; $display("[TB] FAIL reset_dac_val: got %h expected 8000", dac_val); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (burst_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_burst_done: got %b expected 0", burst_done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (sample_idx !== 6'd0) begin errors++; $display("[TB] FAIL reset_sample_idx: got %0d expected 0", sample_idx); end
        checks++; if (cycle_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (start_dac !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_quiet: got start_dac=%b busy=%b expected 0/0", start_dac, busy); end
    endtask

    // One full period at sample_div 8, full scale, 3-clock DAC latency.
    task automatic test_full_period();
        bit ok;
        dac_lat = 3;
        launch(16'd8, 8'd1, 4'd0);
        wait_burst(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL full_timeout: got no burst_done expected burst_done"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_drop: got %b expected 0", busy); end
        repeat (5) @(negedge clk);
        checks++; if (pulse_cnt !== 65) begin errors++; $display("[TB] FAIL full_pulses: got %0d expected 65", pulse_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL full_burst_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL full_overrun: got %b expected 0", overrun); end
        checks++; if (codes[0] !== 16'h8000) begin errors++; $display("[TB] FAIL full_idx0: got %h expected 8000", codes[0]); end
        checks++; if (codes[8] !== 16'hDA82) begin errors++; $display("[TB] FAIL full_idx8: got %h expected da82", codes[8]); end
        checks++; if (codes[16] !== 16'hFFFF) begin errors++; $display("[TB] FAIL full_idx16: got %h expected ffff", codes[16]); end
        checks++; if (codes[32] !== 16'h8000) begin errors++; $display("[TB] FAIL full_idx32: got %h expected 8000", codes[32]); end
        checks++; if (codes[48] !== 16'h0001) begin errors++; $display("[TB] FAIL full_idx48: got %h expected 0001", codes[48]); end
        checks++; if (codes[64] !== 16'h8000) begin errors++; $display("[TB] FAIL full_park: got %h expected 8000", codes[64]); end
        checks++; if (times[1] - times[0] !== 8) begin errors++; $display("[TB] FAIL full_spacing_first: got %0d expected 8", times[1] - times[0]); end
        checks++; if (times[63] - times[62] !== 8) begin errors++; $display("[TB] FAIL full_spacing_last: got %0d expected 8", times[63] - times[62]); end
        checks++; if (cycle_cnt !== 8'd1) begin errors++; $display("[TB] FAIL full_cycle_cnt: got %0d expected 1", cycle_cnt); end
        checks++; if (sample_idx !== 6'd63) begin errors++; $display("[TB] FAIL full_sample_idx: got %0d expected 63", sample_idx); end
        checks++; if (unstable !== 0) begin errors++; $display("[TB] FAIL full_dac_val_hold: got %0d changes expected 0", unstable); end
    endtask

    // amp_shift 4: 32767>>>4 = 2047, -32767>>>4 = -2048, 23170>>>4 = 1448.
    task automatic test_amp_shift();
        bit ok;
        dac_lat = 3;
        launch(16'd8, 8'd1, 4'd4);
        wait_burst(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL amp_timeout: got no burst_done expected burst_done"); end
        checks++; if (codes[8] !== 16'h85A8) begin errors++; $display("[TB] FAIL amp_idx8: got %h expected 85a8", codes[8]); end
        checks++; if (codes[16] !== 16'h87FF) begin errors++; $display("[TB] FAIL amp_idx16: got %h expected 87ff", codes[16]); end
        checks++; if (codes[48] !== 16'h7800) begin errors++; $display("[TB] FAIL amp_idx48: got %h expected 7800", codes[48]); end
        checks++; if (codes[64] !== 16'h8000) begin errors++; $display("[TB] FAIL amp_park: got %h expected 8000", codes[64]); end
    endtask

    // DAC slower than the sample rate: ticks pile up and one is dropped.
    task automatic test_overrun();
        bit ok;
        dac_lat = 10;
        launch(16'd4, 8'd1, 4'd0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pulse_cnt >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL ovr_third_sample: got %0d samples expected 3", pulse_cnt); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); end
        wait_burst(3000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL ovr_timeout: got no burst_done expected burst_done"); end
        checks++; if (pulse_cnt !== 65) begin errors++; $display("[TB] FAIL ovr_pulses: got %0d expected 65", pulse_cnt); end
        checks++; if (codes[16] !== 16'hFFFF) begin errors++; $display("[TB] FAIL ovr_no_skip: got %h expected ffff", codes[16]); end
        checks++; if (codes[64] !== 16'h8000) begin errors++; $display("[TB] FAIL ovr_park: got %h expected 8000", codes[64]); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun); end
    endtask

    // Endless burst aborted during sample 62's transfer, together with its dac_done.
    task automatic test_abort();
        bit ok;
        dac_lat = 3;
        launch(16'd8, 8'd0, 4'd0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL abort_overrun_cleared: got %b expected 0", overrun); end
        repeat (498) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_burst(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL abort_timeout: got no burst_done expected burst_done"); end
        checks++; if (pulse_cnt !== 64) begin errors++; $display("[TB] FAIL abort_pulses: got %0d expected 64", pulse_cnt); end
        checks++; if (codes[62] !== 16'h6707) begin errors++; $display("[TB] FAIL abort_last_sample: got %h expected 6707", codes[62]); end
        checks++; if (codes[63] !== 16'h8000) begin errors++; $display("[TB] FAIL abort_park: got %h expected 8000", codes[63]); end
        checks++; if (sample_idx !== 6'd62) begin errors++; $display("[TB] FAIL abort_sample_idx: got %0d expected 62", sample_idx); end
        repeat (50) @(negedge clk);
        checks++; if (cycle_cnt !== 8'd0) begin errors++; $display("[TB] FAIL abort_cycle_cnt: got %0d expected 0", cycle_cnt); end
        checks++; if (pulse_cnt !== 64 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_quiet: got pulses=%0d busy=%b expected 64/0", pulse_cnt, busy); end
    endtask

    // Re-start while busy, dac_done in idle, and abort+start together in idle.
    task automatic test_back_to_back();
        bit ok;
        dac_lat = 3;
        launch(16'd8, 8'd1, 4'd0);
        repeat (20) @(negedge clk);
        sample_div = 16'd2;
        num_cycles = 8'd3;
        amp_shift  = 4'd4;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_burst(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_timeout: got no burst_done expected burst_done"); end
        checks++; if (pulse_cnt !== 65) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 65", pulse_cnt); end
        checks++; if (codes[16] !== 16'hFFFF) begin errors++; $display("[TB] FAIL b2b_shift_kept: got %h expected ffff", codes[16]); end
        checks++; if (times[4] - times[3] !== 8) begin errors++; $display("[TB] FAIL b2b_div_kept: got %0d expected 8", times[4] - times[3]); end
        checks++; if (cycle_cnt !== 8'd1) begin errors++; $display("[TB] FAIL b2b_ncyc_kept: got %0d expected 1", cycle_cnt); end
        @(posedge clk);
        inject_done = 1'b1;
        @(posedge clk);
        inject_done = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (pulse_cnt !== 65 || busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_done_ignored: got pulses=%0d busy=%b expected 65/0", pulse_cnt, busy); end
        @(negedge clk);
        clear_logs();
        sample_div = 16'd8;
        num_cycles = 8'd1;
        amp_shift  = 4'd0;
        start      = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        abort      = 1'b0;
        wait_burst(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL start_abort_timeout: got no burst_done expected burst_done"); end
        checks++; if (pulse_cnt !== 65) begin errors++; $display("[TB] FAIL start_wins_pulses: got %0d expected 65", pulse_cnt); end
        checks++; if (codes[48] !== 16'h0001) begin errors++; $display("[TB] FAIL start_wins_idx48: got %h expected 0001", codes[48]); end
    endtask

    // Reset during WAIT_DONE, then a fresh burst with sample_div 0 (acts as 2).
    task automatic test_reset_mid_burst();
        bit ok;
        dac_lat = 3;
        launch(16'd8, 8'd1, 4'd0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pulse_cnt >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_second_sample: got %0d samples expected 2", pulse_cnt); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (start_dac !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_start_dac: got %b expected 0", start_dac); end
        checks++; if (dac_val !== 16'h8000) begin errors++; $display("[TB] FAIL rstmid_dac_val: got %h expected 8000", dac_val); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (sample_idx !== 6'd0) begin errors++; $display("[TB] FAIL rstmid_sample_idx: got %0d expected 0", sample_idx); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dac_lat = 1;
        launch(16'd0, 8'd1, 4'd0);
        wait_burst(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_restart_timeout: got no burst_done expected burst_done"); end
        checks++; if (pulse_cnt !== 65) begin errors++; $display("[TB] FAIL rstmid_restart_pulses: got %0d expected 65", pulse_cnt); end
        checks++; if (codes[16] !== 16'hFFFF) begin errors++; $display("[TB] FAIL rstmid_restart_idx16: got %h expected ffff", codes[16]); end
        checks++; if (codes[64] !== 16'h8000) begin errors++; $display("[TB] FAIL rstmid_restart_park: got %h expected 8000", codes[64]); end
    endtask

    initial begin
        test_reset();
        test_full_period();
        test_amp_shift();
        test_overrun();
        test_abort();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
